// File: rtl/vector_check_engine_if.sv
// Vector stream handshake between a stimulus source and the check engine.
interface vector_check_engine_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH_W  = 2
);
  logic             vec_valid;
  logic             vec_ready;
  logic [CH_W-1:0]  vec_ch;
  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_b;
  logic [WIDTH-1:0] vec_exp;
  logic [WIDTH-1:0] vec_mask;

  modport master (
    output vec_valid, vec_ch, vec_a, vec_b, vec_exp, vec_mask,
    input  vec_ready
  );

  modport slave (
    input  vec_valid, vec_ch, vec_a, vec_b, vec_exp, vec_mask,
    output vec_ready
  );
endinterface

// File: rtl/vector_check_engine.sv
// Applies a stream of test vectors to one of NUM_CH DUT channels, compares
// the masked result against the expected word and keeps pass/fail statistics.
module vector_check_engine #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DUT_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        num_vec,
  vector_check_engine_if.slave    vec,
  output logic [NUM_CH-1:0]       dut_sel,
  output logic [WIDTH-1:0]        dut_a,
  output logic [WIDTH-1:0]        dut_b,
  input  logic [NUM_CH*WIDTH-1:0] dut_y,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    first_fail_vld,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic [CNT_W-1:0]        first_fail_idx
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LAT_W = 4;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DUT_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_APPLY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d, num_q, num_d;
  logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d, ffi_q, ffi_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [NUM_CH-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, exp_q, exp_d, mask_q, mask_d;
  logic               ffv_q, ffv_d, abt_q, abt_d;
  logic               busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;

  logic               in_run_c, start_c, accept_c, last_c, cmp_c, pass_c;
  logic [WIDTH-1:0]   y_c;

  assign in_run_c = (state_q == S_FETCH) || (state_q == S_APPLY);
  assign start_c  = start && !in_run_c;
  assign accept_c = (state_q == S_FETCH) && vec.vec_valid && !abort;
  assign last_c   = (state_q == S_APPLY) && (lat_q == LAT_LAST);
  assign cmp_c    = last_c && !abort;

  // Result of the enabled channel; an out-of-range channel has no enable and always fails.
  always_comb begin
    y_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel_q[k]) y_c = dut_y[k*WIDTH +: WIDTH];
    end
  end

  assign pass_c = (sel_q != '0) && (((y_c ^ exp_q) & mask_q) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (num_vec == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (abort)              state_d = S_DONE;
        else if (vec.vec_valid) state_d = S_APPLY;
      end
      S_APPLY: begin
        if (abort)       state_d = S_DONE;
        else if (last_c) state_d = ((idx_q + CNT_W'(1)) == num_q) ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    num_d  = num_q;
    pass_d = pass_q;
    fail_d = fail_q;
    ffi_d  = ffi_q;
    ffv_d  = ffv_q;
    abt_d  = abt_q;
    lat_d  = lat_q;
    exp_d  = exp_q;
    mask_d = mask_q;
    sel_d  = '0;
    a_d    = '0;
    b_d    = '0;
    busy_d = (state_d == S_FETCH) || (state_d == S_APPLY);
    done_d = (state_d == S_DONE);
    rdy_d  = (state_d == S_FETCH);

    if (start_c) begin
      idx_d  = '0;
      num_d  = num_vec;
      pass_d = '0;
      fail_d = '0;
      ffi_d  = '0;
      ffv_d  = 1'b0;
      abt_d  = 1'b0;
    end

    if (in_run_c && abort) abt_d = 1'b1;

    // Operands are held for the whole APPLY window and dropped outside it.
    if (accept_c) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        sel_d[k] = (vec.vec_ch == CH_W'(k));
      end
      a_d    = vec.vec_a;
      b_d    = vec.vec_b;
      exp_d  = vec.vec_exp;
      mask_d = vec.vec_mask;
      lat_d  = '0;
    end else if (state_d == S_APPLY) begin
      sel_d = sel_q;
      a_d   = a_q;
      b_d   = b_q;
      lat_d = lat_q + LAT_W'(1);
    end

    if (cmp_c) begin
      if (pass_c) begin
        pass_d = (pass_q == '1) ? pass_q : pass_q + CNT_W'(1);
      end else begin
        fail_d = (fail_q == '1) ? fail_q : fail_q + CNT_W'(1);
        if (!ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = idx_q;
        end
      end
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      num_q  <= '0;
      pass_q <= '0;
      fail_q <= '0;
      ffi_q  <= '0;
      ffv_q  <= 1'b0;
      abt_q  <= 1'b0;
      lat_q  <= '0;
      exp_q  <= '0;
      mask_q <= '0;
      sel_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      num_q  <= num_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ffi_q  <= ffi_d;
      ffv_q  <= ffv_d;
      abt_q  <= abt_d;
      lat_q  <= lat_d;
      exp_q  <= exp_d;
      mask_q <= mask_d;
      sel_q  <= sel_d;
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rdy_q  <= rdy_d;
    end
  end

  assign vec.vec_ready    = rdy_q;
  assign dut_sel          = sel_q;
  assign dut_a            = a_q;
  assign dut_b            = b_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign aborted          = abt_q;
  assign first_fail_vld   = ffv_q;
  assign pass_cnt         = pass_q;
  assign fail_cnt         = fail_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_vector_check_engine.sv
// Directed bench for vector_check_engine: three channels (add, sub, xor), DUT_LAT=3.
module tb_vector_check_engine;
  localparam int unsigned W   = 32;
  localparam int unsigned NCH = 3;
  localparam int unsigned LAT = 3;
  localparam int unsigned CW  = 16;
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_APPLY = 2, ST_DONE = 3;

  logic clk, rst_n, start, abort;
  logic [CW-1:0]    num_vec;
  logic [NCH-1:0]   dut_sel;
  logic [W-1:0]     dut_a, dut_b;
  logic [NCH*W-1:0] dut_y;
  logic busy, done, aborted, first_fail_vld;
  logic [CW-1:0] pass_cnt, fail_cnt, first_fail_idx;

  vector_check_engine_if #(.WIDTH(W), .CH_W(2)) vif ();

  vector_check_engine #(.WIDTH(W), .NUM_CH(NCH), .DUT_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .vec(vif.slave), .dut_sel(dut_sel), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .busy(busy), .done(done), .aborted(aborted), .first_fail_vld(first_fail_vld),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx)
  );

  // Device channels: 0 adder, 1 subtractor, 2 xor.
  assign dut_y = {dut_a ^ dut_b, dut_a - dut_b, dut_a + dut_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       ch;
    logic [W-1:0] a, b, e, m;
    int       gap;
    bit       st;
    int       ab;   // 0 none, 1..LAT abort on that APPLY cycle, 99 abort in FETCH
  } vec_t;

  int total = 0, bad = 0;
  bit mon_en = 0;
  vec_t vq[$];

  // Expected engine status
  int e_state, e_idx, e_num, e_ch;
  logic [CW-1:0] e_pass, e_fail, e_ffi;
  bit e_ffv, e_abt;
  logic [W-1:0] e_a, e_b;

  function automatic vec_t mk(int ch, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] e,
                              logic [W-1:0] m, int gap, bit st, int ab);
    vec_t v;
    v.ch = ch; v.a = a; v.b = b; v.e = e; v.m = m; v.gap = gap; v.st = st; v.ab = ab;
    return v;
  endfunction

  function automatic logic [W-1:0] golden(int ch, logic [W-1:0] a, logic [W-1:0] b);
    case (ch)
      0: return a + b;
      1: return a - b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    e_state = ST_IDLE; e_idx = 0; e_num = 0; e_ch = 0;
    e_pass = '0; e_fail = '0; e_ffi = '0; e_ffv = 0; e_abt = 0; e_a = '0; e_b = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_cycle();
    logic [NCH-1:0] es;
    bit app;
    app = (e_state == ST_APPLY);
    es = '0;
    if (app && e_ch < int'(NCH)) es[e_ch] = 1'b1;
    chk("vec_ready", W'(vif.vec_ready), W'(e_state == ST_FETCH));
    chk("busy", W'(busy), W'(e_state == ST_FETCH || app));
    chk("done", W'(done), W'(e_state == ST_DONE));
    chk("aborted", W'(aborted), W'(e_abt));
    chk("dut_sel", W'(dut_sel), W'(es));
    chk("dut_a", dut_a, app ? e_a : '0);
    chk("dut_b", dut_b, app ? e_b : '0);
    chk("pass_cnt", W'(pass_cnt), W'(e_pass));
    chk("fail_cnt", W'(fail_cnt), W'(e_fail));
    chk("ff_vld", W'(first_fail_vld), W'(e_ffv));
    chk("ff_idx", W'(first_fail_idx), W'(e_ffi));
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    num_vec = CW'(n);
    tick();
    start = 1'b0;
    if (e_state == ST_IDLE || e_state == ST_DONE) begin
      e_pass = '0; e_fail = '0; e_ffi = '0; e_ffv = 0; e_abt = 0;
      e_idx = 0; e_num = n;
      e_state = (n == 0) ? ST_DONE : ST_FETCH;
    end
  endtask

  task automatic send_vec(input vec_t v);
    bit ok;
    for (int g = 0; g < v.gap; g++) begin
      vif.vec_valid = 1'b0;
      start = v.st;
      num_vec = CW'(9);
      tick();
    end
    start = 1'b0;
    if (v.ab == 99) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      e_state = ST_DONE; e_abt = 1;
      return;
    end
    vif.vec_valid = 1'b1;
    vif.vec_ch = 2'(v.ch);
    vif.vec_a = v.a; vif.vec_b = v.b; vif.vec_exp = v.e; vif.vec_mask = v.m;
    tick();
    vif.vec_valid = 1'b0;
    e_state = ST_APPLY; e_ch = v.ch; e_a = v.a; e_b = v.b;
    for (int c = 1; c <= int'(LAT); c++) begin
      if (c == v.ab) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        e_state = ST_DONE; e_abt = 1;
        return;
      end
      tick();
      if (c == int'(LAT)) begin
        ok = (v.ch < int'(NCH)) && (((golden(v.ch, v.a, v.b) ^ v.e) & v.m) == '0);
        if (ok) e_pass = (e_pass == '1) ? e_pass : e_pass + 1'b1;
        else begin
          e_fail = (e_fail == '1) ? e_fail : e_fail + 1'b1;
          if (!e_ffv) begin e_ffv = 1; e_ffi = CW'(e_idx); end
        end
        e_idx++;
        e_state = (e_idx == e_num) ? ST_DONE : ST_FETCH;
      end
    end
  endtask

  task automatic run_q(input int n);
    start_run(n);
    foreach (vq[i]) if (e_state == ST_FETCH) send_vec(vq[i]);
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; num_vec = '0;
    vif.vec_valid = 1'b0; vif.vec_ch = '0; vif.vec_a = '0; vif.vec_b = '0;
    vif.vec_exp = '0; vif.vec_mask = '0;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        if (mon_en) monitor_cycle();
      end
    join_none
    #2 rst_n = 1'b0;
    mon_en = 1;
    tick(); tick();
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    rst_n = 1'b1;
    tick();

    // Run A: three adder vectors, all pass
    vq = {};
    vq.push_back(mk(0, 1, 2, 3, '1, 0, 0, 0));
    vq.push_back(mk(0, 5, 5, 10, '1, 0, 0, 0));
    vq.push_back(mk(0, 7, 1, 8, '1, 0, 0, 0));
    run_q(3);
    chk("A_done", W'(done), 1);
    chk("A_pass", W'(pass_cnt), 3);
    chk("A_fail", W'(fail_cnt), 0);
    chk("A_ffv", W'(first_fail_vld), 0);

    // Run B: vector 2 wrong in bit 0; vector 1 stalls 5 cycles with start held high
    vq = {};
    vq.push_back(mk(0, 3, 4, 7, '1, 0, 0, 0));
    vq.push_back(mk(1, 10, 3, 7, '1, 5, 1, 0));
    vq.push_back(mk(2, 32'hF0, 32'h0F, 32'hFE, '1, 0, 0, 0));
    vq.push_back(mk(0, 32'hFFFF_FFFF, 1, 0, '1, 0, 0, 0));
    run_q(4);
    chk("B_pass", W'(pass_cnt), 3);
    chk("B_fail", W'(fail_cnt), 1);
    chk("B_ffv", W'(first_fail_vld), 1);
    chk("B_ffi", W'(first_fail_idx), 2);

    // Run C: same, bit 0 masked off
    vq[2].m = 32'hFFFF_FFFE;
    run_q(4);
    chk("C_pass", W'(pass_cnt), 4);
    chk("C_fail", W'(fail_cnt), 0);

    // Run D: abort on 2nd APPLY cycle of vector 1, then abort while in DONE
    vq = {};
    vq.push_back(mk(0, 1, 1, 2, '1, 0, 0, 0));
    vq.push_back(mk(1, 9, 4, 5, '1, 0, 0, 2));
    vq.push_back(mk(0, 1, 1, 2, '1, 0, 0, 0));
    run_q(3);
    chk("D_aborted", W'(aborted), 1);
    chk("D_pass", W'(pass_cnt), 1);
    chk("D_fail", W'(fail_cnt), 0);
    abort = 1'b1; tick(); abort = 1'b0; tick();

    // Run E: abort coincides with the compare of a failing vector
    vq = {};
    vq.push_back(mk(0, 1, 1, 9, '1, 0, 0, int'(LAT)));
    run_q(2);
    chk("E_fail", W'(fail_cnt), 0);
    chk("E_aborted", W'(aborted), 1);

    // Run F: empty run goes straight to DONE
    run_q(0);
    chk("F_done", W'(done), 1);
    chk("F_aborted", W'(aborted), 0);

    // Run G: invalid channel fails, second fail keeps index 0, abort in FETCH
    vq = {};
    vq.push_back(mk(3, 1, 1, 2, '1, 0, 0, 0));
    vq.push_back(mk(0, 2, 2, 5, '1, 1, 0, 0));
    vq.push_back(mk(0, 2, 2, 4, '1, 2, 0, 99));
    run_q(3);
    chk("G_fail", W'(fail_cnt), 2);
    chk("G_ffi", W'(first_fail_idx), 0);

    // Reset in the middle of APPLY, then no resume after release
    start_run(2);
    vif.vec_valid = 1'b1; vif.vec_ch = 2'd0;
    vif.vec_a = 32'h55; vif.vec_b = 32'h11; vif.vec_exp = 32'h66; vif.vec_mask = '1;
    tick();
    vif.vec_valid = 1'b0;
    e_state = ST_APPLY; e_ch = 0; e_a = 32'h55; e_b = 32'h11;
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("R_sel", W'(dut_sel), 0);
    chk("R_a", dut_a, 0);
    chk("R_busy", W'(busy), 0);
    tick();
    rst_n = 1'b1;
    vif.vec_valid = 1'b1;
    tick(); tick(); tick();
    vif.vec_valid = 1'b0;

    // Run H: clean run after reset
    vq = {};
    vq.push_back(mk(2, 32'hA5A5, 32'h5A5A, 32'hFFFF, '1, 0, 0, 0));
    run_q(1);
    chk("H_pass", W'(pass_cnt), 1);

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_check_engine.md
VECTOR_CHECK_ENGINE -- requirements
Module: vector_check_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of stimulus, expected and DUT result words.
REQ-002 SHALL have parameter NUM_CH, default 4, number of DUT channels (adder, carry adder, ALU, mux, ...).
REQ-003 SHALL have parameter DUT_LAT, default 1, range 1..15, cycles each vector is applied before the result is sampled.
REQ-004 SHALL have parameter CNT_W, default 16, width of vector index and pass/fail counters.
REQ-005 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have start  input  1  one-cycle request to begin a run.
REQ-008 SHALL have abort  input  1  terminate the current run.
REQ-009 SHALL have num_vec  input  CNT_W  vectors in the run, sampled when start is accepted.
REQ-010 SHALL have vec_valid  input  1  and vec_ready  output  1  as the vector stream handshake.
REQ-011 SHALL have vec_ch  input  clog2(NUM_CH)  target channel; vec_a, vec_b, vec_exp, vec_mask  input  WIDTH each  stimulus operands, expected result, compare mask.
REQ-012 SHALL have dut_sel  output  NUM_CH  one-hot channel enable; dut_a, dut_b  output  WIDTH  applied operands.
REQ-013 SHALL have dut_y  input  NUM_CH*WIDTH  concatenated channel results, channel k at bits [k*WIDTH +: WIDTH].
REQ-014 SHALL have busy, done, aborted, first_fail_vld  output  1 each; pass_cnt, fail_cnt, first_fail_idx  output  CNT_W each.

Function
REQ-015 SHALL implement states IDLE, FETCH, APPLY, DONE.
REQ-016 IDLE/DONE: start=1 SHALL clear pass_cnt, fail_cnt, first_fail_vld, first_fail_idx, aborted, index, latch num_vec, and enter FETCH; if num_vec=0 SHALL enter DONE instead.
REQ-017 start while in FETCH or APPLY SHALL be ignored.
REQ-018 vec_ready SHALL be 1 only in FETCH; a vector SHALL be accepted on a cycle with vec_valid & vec_ready, moving to APPLY; FETCH SHALL wait indefinitely for vec_valid.
REQ-019 vec_ch >= NUM_CH SHALL be accepted and counted as a fail with no channel enabled.
REQ-020 APPLY SHALL last exactly DUT_LAT cycles, driving registered dut_sel=onehot(vec_ch), dut_a=vec_a, dut_b=vec_b, stable throughout.
REQ-021 Outside APPLY, dut_sel, dut_a, dut_b SHALL be 0.
REQ-022 On the last APPLY cycle, dut_y of the selected channel SHALL be compared: pass iff ((y ^ vec_exp) & vec_mask) == 0.
REQ-023 pass_cnt or fail_cnt SHALL increment at that edge; counters SHALL saturate at all-ones.
REQ-024 First fail of a run SHALL set first_fail_vld=1 and first_fail_idx=vector index (0-based); later fails SHALL not change them.
REQ-025 After the compare, index SHALL increment; if index+1 = latched num_vec next state SHALL be DONE, else FETCH; steady throughput is one vector per DUT_LAT+1 cycles.
REQ-026 busy SHALL be 1 in FETCH and APPLY; done SHALL be 1 in DONE and held until the next accepted start.
REQ-027 abort=1 in FETCH or APPLY SHALL enter DONE next edge with aborted=1, no compare of the in-flight vector, counters held; abort in IDLE/DONE SHALL be ignored.
REQ-028 abort and last-cycle compare in the same cycle: abort SHALL win, vector not counted.
REQ-029 Status outputs SHALL remain readable and unchanged in DONE.

Reset
REQ-030 reset=0 SHALL immediately force IDLE and zero all outputs, counters, index and latched registers, regardless of state.
REQ-031 Deassertion mid-vector SHALL not resume the run; a new start is required.

Verification
REQ-032 num_vec=3, DUT_LAT=1, channel 0 adder, vectors (1+2 exp 3),(5+5 exp 10),(7+1 exp 8) -> done after 6 cycles of vec_valid, pass_cnt=3, fail_cnt=0, first_fail_vld=0.
REQ-033 num_vec=4, vector 2 exp wrong in bit 0, mask=all-ones -> pass_cnt=3, fail_cnt=1, first_fail_idx=2; same with mask bit 0 cleared -> pass_cnt=4.
REQ-034 vec_valid held low 5 cycles in FETCH -> vec_ready stays 1, dut_sel=0, no counter change; then proceeds normally.
REQ-035 abort asserted on 2nd APPLY cycle of vector 1 with DUT_LAT=3 -> DONE next cycle, aborted=1, pass_cnt=1, fail_cnt=0.
REQ-036 num_vec=0 start -> done=1 next cycle, counters 0; start during busy -> no effect; reset=0 during APPLY -> all outputs 0 asynchronously, IDLE.
REQ-037 vec_ch=NUM_CH -> dut_sel=0 in APPLY, fail_cnt increments.
